serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial a - b - bin engine; the inverse operation to the team's parallel ripple adder.
//  Consumes one bit pair per clock, LSB first, through a single full-subtractor cell and a
//  borrow flop.
//  Used where area matters more than latency.
//  Its results are cross-checked against the ripple adder: a == diff + b + bin.
// PARAMETERS
//  WIDTH  4  operand and difference width in bits (>= 2)
// PORTS
//  clk     in   1      single clock, all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  start   in   1      request; sampled only when ready=1
//  a       in   WIDTH  minuend, captured on accepted start
//  b       in   WIDTH  subtrahend, captured on accepted start
//  bin     in   1      borrow-in, captured on accepted start
//  ready   out  1      1 in IDLE and DONE (new start accepted)
//  busy    out  1      1 while in SHIFT
//  done    out  1      one-cycle pulse, result valid
//  diff    out  WIDTH  difference, held until the next result
//  borrow  out  1      borrow-out, held until the next result
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, diff=0, borrow=0, done=0, busy=0, ready=1.
//   Internal operand, borrow and bit-count registers are also cleared.
//   Reset overrides everything, including a start in the same cycle.
//  Arithmetic: {borrow,diff} = {1'b0,a} - {1'b0,b} - bin, modulo 2^(WIDTH+1).
//   borrow=1 iff a < b+bin (unsigned).
//  Per bit i: d_i = a_i ^ b_i ^ br.
//   br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
//   br starts at the captured bin.
//  FSM:
//   IDLE: start=1 -> capture a, b, bin; count=0; go to SHIFT.
//   SHIFT: compute one bit per cycle; shift the partial result in from the MSB side;
//    count++. After bit WIDTH-1 -> DONE, updating diff/borrow in the same edge.
//   DONE: done=1 for this cycle only. start=1 -> capture and go to SHIFT (back-to-back);
//    otherwise go to IDLE.
//  Latency: start accepted at edge T -> done=1 and diff/borrow valid in the cycle after
//   edge T+WIDTH.
//   Back-to-back throughput is one result per WIDTH+1 cycles.
//  start while busy=1: ignored. No queuing, and the in-flight operation is unaffected.
//  Operands may change freely after the capture edge; only the captured values are used.
//  diff/borrow never show partial results; they change only on the SHIFT->DONE edge or on reset.
//  Reset mid-SHIFT: the operation is abandoned, no done pulse, and outputs clear to 0.
//  Bit counter is clog2(WIDTH) wide; no wrap is visible outside SHIFT.
// TESTING
//  Reset, then a=0101 b=0011 bin=0 start -> done in the cycle after T+4; diff=0010 borrow=0.
//  a=0011 b=0101 bin=0 -> diff=1110 borrow=1.
//   a=0000 b=0000 bin=1 -> diff=1111 borrow=1.
//   a=1111 b=1111 bin=1 -> diff=1111 borrow=1.
//  Pulse start again 2 cycles into SHIFT with different operands.
//   -> ignored; the first result is unchanged; exactly one done pulse.
//  Hold start=1 continuously, exercising back-to-back operation.
//   -> done every 5 cycles; each result matches the operands present at its capture edge.
//  Assert rst for one cycle mid-SHIFT -> no done pulse; diff=0, borrow=0, ready=1 next cycle.
//   A subsequent op completes correctly.
//  Exhaustive: all 512 (a,b,bin) combinations at WIDTH=4.
//   Check {borrow,diff} against the reference model.
//   Check a == (diff + b + bin) mod 16.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial engine computing {borrow,diff} = a - b - bin (unsigned, WIDTH bits).
//   The operands are captured on an accepted start. One bit pair is then consumed
//   per clock, LSB first, through a single full-subtractor cell and a borrow flop.
//   The result registers are updated only when the final bit is produced, so
//   diff/borrow never expose a partial result.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   start   in   1      operation request, honoured only while ready=1
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   bin     in   1      borrow-in, captured on accepted start
//   ready   out  1      high in IDLE and DONE
//   busy    out  1      high while bits are being shifted
//   done    out  1      one-cycle pulse when diff/borrow carry a new result
//   diff    out  WIDTH  difference, held until the next result
//   borrow  out  1      borrow-out, held until the next result
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; last result held
// SHIFT | one bit of the difference produced per cycle
// DONE  | result just written; done pulses; start here chains the next op
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part;
  logic             br;
  logic [CW-1:0]    cnt;

  logic capture;
  logic last_bit;
  logic d_bit;
  logic br_nxt;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    capture   = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          last_bit  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          capture   = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      part   <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (capture) begin
      a_sh <= a;
      b_sh <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (busy) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      br   <= br_nxt;
      cnt  <= cnt + 1'b1;
      // Each new bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
      part <= {d_bit, part[WIDTH-1:1]};
      if (last_bit) begin
        diff   <= {d_bit, part[WIDTH-1:1]};
        borrow <= br_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [3:0] diff;
  logic       borrow;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction; borrow is the sign of the true result.
  function automatic logic [4:0] ref_sub(input logic [3:0] x, input logic [3:0] y,
                                         input logic c);
    int r;
    r = int'(x) - int'(y) - int'(c);
    return {(r < 0), 4'(r)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT ready; returns at the negedge showing done.
  task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
    int         cyc;
    logic [3:0] pd;
    logic       pb;
    logic [4:0] e;
    chk("ready_before_start", ready, 1);
    pd    = diff;
    pb    = borrow;
    a     = ta;
    b     = tb;
    bin   = tc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    bin   = 1'($urandom);
    cyc   = 1;
    chk("busy_after_accept", busy, 1);
    while (done !== 1'b1 && cyc < 20) begin
      chk("no_partial_result", {borrow, diff}, {pb, pd});
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, 5);
    e = ref_sub(ta, tb, tc);
    chk("diff", diff, e[3:0]);
    chk("borrow", borrow, e[4]);
    chk("ripple_crosscheck", 4'(diff + tb + 4'(tc)), ta);
    chk("ready_in_done", ready, 1);
  endtask

  initial begin
    logic [4:0] q[$];
    logic [4:0] e;
    int         ndone;
    int         last_done;

    // Reset asserted together with start: reset must win.
    rst   = 1'b1;
    start = 1'b1;
    a     = 4'hA;
    b     = 4'h3;
    bin   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {ready, busy, done}, 3'b100);

    // Directed vectors with literal expectations.
    run_op(4'b0101, 4'b0011, 1'b0);
    chk("vec1", {borrow, diff}, 5'b0_0010);
    @(negedge clk);
    run_op(4'b0011, 4'b0101, 1'b0);
    chk("vec2", {borrow, diff}, 5'b1_1110);
    @(negedge clk);
    run_op(4'b0000, 4'b0000, 1'b1);
    chk("vec3", {borrow, diff}, 5'b1_1111);
    @(negedge clk);
    run_op(4'b1111, 4'b1111, 1'b1);
    chk("vec4", {borrow, diff}, 5'b1_1111);
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_done", {ready, busy, done}, 3'b100);

    // start pulsed two cycles into SHIFT must be ignored.
    a     = 4'd9;
    b     = 4'd2;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a     = 4'd1;
    b     = 4'd8;
    bin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) begin
        ndone++;
        chk("ignored_start_result", {borrow, diff}, 5'b0_0111);
      end
      @(negedge clk);
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_held", {borrow, diff}, 5'b0_0111);

    // Back-to-back: start held high, operands changing every cycle.
    ndone     = 0;
    last_done = -1;
    start     = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (done === 1'b1) begin
        ndone++;
        if (last_done >= 0) chk("b2b_period", cyc - last_done, 5);
        last_done = cyc;
        chk("b2b_queue_nonempty", (q.size() > 0), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("b2b_result", {borrow, diff}, e);
        end
      end
      if (cyc == 70) start = 1'b0;
      a   = 4'($urandom);
      b   = 4'($urandom);
      bin = 1'($urandom);
      if (ready === 1'b1 && start === 1'b1) q.push_back(ref_sub(a, b, bin));
      @(negedge clk);
    end
    chk("b2b_all_completed", q.size(), 0);
    chk("b2b_done_count", (ndone >= 14), 1);

    // Reset mid-SHIFT abandons the operation.
    run_op(4'd12, 4'd3, 1'b0);
    @(negedge clk);
    a     = 4'd13;
    b     = 4'd1;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_diff", diff, 0);
    chk("midrst_borrow", borrow, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_busy", busy, 0);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_done", ndone, 0);
    run_op(4'd6, 4'd9, 1'b1);
    @(negedge clk);

    // Random single operations.
    for (int i = 0; i < 30; i++) begin
      run_op(4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    // Exhaustive sweep of all operand combinations.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run_op(4'(ia), 4'(ib), 1'(ic));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
